// File: rtl/mem_responder.sv
// Purpose: single-outstanding load/store responder in front of a word-organised RAM, with byte-lane steering.
// Latency: the access happens WAIT_STATES+1 edges after acceptance; rsp_valid is a one-cycle strobe on the next cycle.
// Backpressure: req_ready drops from acceptance until the response retires; the response itself cannot be stalled.
// Optional feature macro: MEM_RESPONDER_MISALIGN_ERR_EN (rejects misaligned half/word accesses with rsp_err).
`timescale 1ns/1ps

module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [1:0]      mode_q;
    logic [1:0]      off_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [1:0]      lane_base;
    logic [3:0]      be;
    logic [31:0]     mask;
    logic [4:0]      shamt;
    logic [31:0]     rd_word;
    logic [31:0]     ld_data;
    logic [31:0]     st_data;
    logic            reject;
    logic            access;
    logic            do_write;

    // Address bits above the RAM window only exist to make addresses wrap.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    // Lane decode: misaligned half/word requests collapse onto their aligned lane base.
    always_comb begin
        lane_base = 2'b00;
        be        = 4'b1111;
        mask      = 32'hFFFF_FFFF;
        case (mode_q)
            2'b10: begin
                lane_base = off_q;
                be        = 4'b0001 << off_q;
                mask      = 32'h0000_00FF;
            end
            2'b01: begin
                lane_base = {off_q[1], 1'b0};
                be        = 4'b0011 << {off_q[1], 1'b0};
                mask      = 32'h0000_FFFF;
            end
            default: begin
                lane_base = 2'b00;
                be        = 4'b1111;
                mask      = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign shamt   = {lane_base, 3'b000};
    assign rd_word = mem_q[idx_q];
    assign ld_data = (rd_word >> shamt) & mask;
    assign st_data = wdata_q << shamt;

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    assign reject = ((mode_q == 2'b01) && off_q[0]) ||
                    (((mode_q == 2'b00) || (mode_q == 2'b11)) && (off_q != 2'b00));
`else
    assign reject = 1'b0;
`endif

    assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_write = access && we_q && !reject;

    // RAM write port: only the enabled byte lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx_q][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    logic rsp_err_q;

    // Error flag is captured at the access edge and held until the next response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err_q <= 1'b0;
        end else if (access) begin
            rsp_err_q <= reject;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Request FSM: accept, count down wait states, access, one-cycle response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            mode_q      <= 2'b00;
            off_q       <= 2'b00;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        mode_q      <= req_mode;
                        off_q       <= req_addr[1:0];
                        idx_q       <= req_addr[AW+1:2];
                        wdata_q     <= req_wdata;
                        cnt_q       <= WS_CNT;
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Stores and rejected requests return zero data.
                        rsp_rdata_q <= (reject || we_q) ? 32'd0 : ld_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: scoreboard bench for mem_responder; two instances (1 and 3 wait states) share request buses.
// Latency: every response is checked to arrive WAIT_STATES+1 edges after acceptance.
// Backpressure: the driver holds each request until req_ready is seen at the accepting edge.
`timescale 1ns/1ps

module tb_mem_responder;

    localparam int WS_A = 1;
    localparam int WS_B = 3;

    logic        clk = 1'b0;
    logic        reset_n_a, reset_n_b;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [1:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a, rsp_err_b;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_b_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for instance A: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                ea = q_a.pop_front();
                check("a_err", 32'(rsp_err_a), 32'(ea.err));
                if (ea.chk_rd) check("a_rdata", rsp_rdata_a, ea.rd);
                check("a_latency", 32'(cyc - ea.acc_cyc), 32'(WS_A + 1));
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (rsp_valid_b === 1'b1) begin
            rsp_b_seen++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                eb = q_b.pop_front();
                check("b_err", 32'(rsp_err_b), 32'(eb.err));
                if (eb.chk_rd) check("b_rdata", rsp_rdata_b, eb.rd);
                check("b_latency", 32'(cyc - eb.acc_cyc), 32'(WS_B + 1));
            end
        end
    end

    task automatic issue(input bit sel, input bit expect_rsp, input logic we, input logic [1:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        while (((sel ? req_ready_b : req_ready_a) !== 1'b1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 for 100 cycles expected 1 (addr 0x%08h)", addr);
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        if (expect_rsp) begin
            e.chk_rd  = chk_rd;
            e.rd      = exp_rd;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
    endtask

    task automatic st_a(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wdata);
        issue(1'b0, 1'b1, 1'b1, mode, addr, wdata, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic ld_a(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] exp_rd);
        issue(1'b0, 1'b1, 1'b0, mode, addr, 32'd0, 1'b0, 1'b1, exp_rd);
    endtask

    task automatic drain(input bit sel);
        int waited;
        waited = 0;
        while (((sel ? q_b.size() : q_a.size()) != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if ((sel ? q_b.size() : q_a.size()) != 0) begin
            errors++;
            $display("FAIL drain_%0d: got %0d outstanding responses expected 0", sel,
                     sel ? q_b.size() : q_a.size());
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_a   = 1'b0;
        reset_n_b   = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_mode    = 2'b00;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready_a), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rsp_err",   32'(rsp_err_a),   32'd0);
        check("rst_rsp_rdata", rsp_rdata_a,      32'd0);
        check("rst_b_ready",   32'(req_ready_b), 32'd1);

        // Word round trip.
        st_a(2'b00, 32'h10, 32'hDEAD_BEEF);
        ld_a(2'b00, 32'h10, 32'hDEAD_BEEF);

        // Byte-lane merge; junk in unused upper wdata bits must not leak.
        st_a(2'b00, 32'h20, 32'h1122_3344);
        st_a(2'b10, 32'h22, 32'h1234_56AA);
        st_a(2'b01, 32'h20, 32'hFFFF_BBCC);
        ld_a(2'b00, 32'h20, 32'h11AA_BBCC);
        ld_a(2'b10, 32'h23, 32'h0000_0011);
        ld_a(2'b01, 32'h22, 32'h0000_11AA);
        ld_a(2'b10, 32'h21, 32'h0000_00BB);

        // Misaligned accesses.
        st_a(2'b00, 32'h30, 32'h7766_5544);
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
        issue(1'b0, 1'b1, 1'b1, 2'b01, 32'h31, 32'h0000_5555, 1'b1, 1'b1, 32'd0);
        ld_a(2'b00, 32'h30, 32'h7766_5544);
        issue(1'b0, 1'b1, 1'b0, 2'b00, 32'h32, 32'd0, 1'b1, 1'b1, 32'd0);
`else
        issue(1'b0, 1'b1, 1'b1, 2'b01, 32'h31, 32'h0000_5555, 1'b0, 1'b0, 32'd0);
        ld_a(2'b00, 32'h30, 32'h7766_5555);
        ld_a(2'b00, 32'h32, 32'h7766_5555);
`endif

        // Address wrap-around and mode 11 behaving as word.
        st_a(2'b00, 32'h400, 32'h1234_5678);
        ld_a(2'b00, 32'h000, 32'h1234_5678);
        ld_a(2'b01, 32'h402, 32'h0000_1234);
        ld_a(2'b11, 32'h10, 32'hDEAD_BEEF);
        ld_a(2'b00, 32'hFFFF_FC20, 32'h11AA_BBCC);
        drain(1'b0);

        // Reset in the middle of a 3-wait-state store.
        issue(1'b1, 1'b1, 1'b1, 2'b00, 32'h40, 32'h0BAD_BEEF, 1'b0, 1'b0, 32'd0);
        drain(1'b1);
        rsp_b_seen = 0;
        issue(1'b1, 1'b0, 1'b1, 2'b00, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n_b = 1'b0;
        @(negedge clk);
        reset_n_b = 1'b1;
        repeat (10) @(negedge clk);
        check("b_no_rsp_after_reset", 32'(rsp_b_seen), 32'd0);
        check("b_ready_after_reset", 32'(req_ready_b), 32'd1);
        issue(1'b1, 1'b1, 1'b0, 2'b00, 32'h40, 32'd0, 1'b0, 1'b1, 32'h0BAD_BEEF);
        drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core's data/instruction port. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. Stores are steered into the addressed byte lanes according to the core's byte/half/word store mode. Each request gets a single-cycle response with read data and an error flag. It sits between the core's memory-address/write-data path and a word-organised on-chip RAM held inside this block.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 1: extra busy cycles per access, 0..15.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data, right-justified, upper bits zero; core performs sign/zero extension.
- rsp_err  out  1  request rejected; valid only with rsp_valid.

## Operation
- **FSM states:**
  - IDLE: req_ready=1. On req_valid&req_ready, latch we/mode/addr/wdata, load cnt=WAIT_STATES, go to BUSY.
  - BUSY: req_ready=0. If cnt≠0, decrement. If cnt==0, perform the access and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- **Word index:** addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- **Byte lane, off=addr[1:0]:**
  - Byte: lane off; write wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1}; write wdata[15:0].
  - Word: all four lanes.
  - Unselected lanes are never modified.
- **Load:** the RAM word is shifted right by 8×lane base. It is masked to 8, 16 or 32 bits per mode and held in rsp_rdata.
- **Error (when compiled in):** half with addr[0]=1, or word with addr[1:0]≠0. No RAM write occurs, rsp_rdata=0, rsp_err=1.
- No response back-pressure: the core always consumes rsp_valid in its cycle.
- Requests presented while req_ready=0 are ignored and must be held by the initiator.

## Timing
- **Reset values:** state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0. RAM contents are undefined and not cleared.
- **Latency:** the request is accepted at edge E0. The RAM access happens at edge E0+WAIT_STATES+1. rsp_valid is high from that edge until E0+WAIT_STATES+2.
- **Throughput:** the next request can be accepted at E0+WAIT_STATES+3, i.e. one request per WAIT_STATES+3 cycles.
- rsp_rdata and rsp_err hold their values until the next response. They are only meaningful while rsp_valid=1.
- **Reset mid-operation:** a reset asserted in BUSY drops the request. If it lands before the access edge, no RAM write occurs, and no rsp_valid is produced. A write already performed stays in RAM.
- **WAIT_STATES=0:** BUSY lasts one cycle. Latency is 1 cycle after acceptance.
- **Same-address store then load:** the load returns the merged bytes written by the store.

## Configuration
- Macro MEM_RESPONDER_MISALIGN_ERR_EN.
- **Defined:** misaligned half/word requests are rejected as described in Operation.
- **Undefined:** rsp_err is tied to 0. Misaligned requests are silently aligned: half clears addr[0], word clears addr[1:0]. The access then proceeds normally.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles, then release. Required: req_ready=1, rsp_valid=0, rsp_err=0.
- **Word round-trip, WAIT_STATES=1:**
  - Store word 0xDEADBEEF @0x10. rsp_valid must rise 2 cycles after acceptance with rsp_err=0.
  - Load word @0x10. Required: rsp_rdata=0xDEADBEEF.
- **Byte lanes:**
  - Store word 0x11223344 @0x20.
  - Store byte 0xAA @0x22.
  - Store half 0xBBCC @0x20.
  - Load word @0x20. Required: 0x11AABBCC.
  - Load byte @0x23. Required: 0x00000011.
- **Misalign (macro defined):**
  - Store half 0x5555 @0x31. Required: rsp_err=1, rsp_rdata=0.
  - Load word @0x30. Required: unchanged prior value.
  - With the macro undefined, the same store writes lanes 0–1 of @0x30.
- **Wrap-around, DEPTH_WORDS=256:** store word 0x12345678 @0x400. Load @0x000. Required: 0x12345678.
- **Reset mid-operation:** store word 0xCAFEF00D @0x40 with WAIT_STATES=3. Pulse reset_n low in the 2nd BUSY cycle.
  - Required: no rsp_valid is produced.
  - A subsequent load @0x40 returns the pre-store contents.
